// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch prefetch queue.
//   WORD_WIDTH        width of instruction words and PCs
//   PC_STEP           distance between consecutive instruction addresses
//   RESET_PC_DEFAULT  default first fetch address after reset
//   fetch_entry_t     one queued instruction: {pc4, code}
//   next_pc()         sequential PC advance, modulo 2^32
// ---------------------------------------------------------------------------
package if_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [WORD_WIDTH-1:0] PC_STEP = 32'd4;

    localparam logic [WORD_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc4;
        logic [WORD_WIDTH-1:0] code;
    } fetch_entry_t;

    // Wraps naturally at the top of the address space (0xFFFF_FFFC -> 0x0).
    function automatic logic [WORD_WIDTH-1:0] next_pc(input logic [WORD_WIDTH-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// ---------------------------------------------------------------------------
// prefetch_fifo
// Synchronous FIFO of fetch_entry_t holding returned instructions.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset
//   flush    empty the FIFO (wins over push and pop)
//   push     write push_data at the tail
//   push_data entry to write
//   pop      advance the head
//   full     count == DEPTH
//   empty    count == 0
//   count    number of valid entries (0..DEPTH)
//   head     entry at the head (meaningful only while !empty)
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module prefetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only honoured when the head leaves in the
    // same cycle; a pop of an empty FIFO is ignored.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!flush && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue
// Instruction-fetch front end feeding the IF/ID register. Issues sequential
// fetch requests, buffers in-order responses tagged with PC+4, and hands them
// to ID under valid/ready. A redirect flushes the queue, restarts fetch at
// redirect_pc and discards every response still owed by the memory.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   redirect_valid  flush and restart at redirect_pc
//   redirect_pc     new fetch address (word-aligned)
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts the request
//   imem_req_addr   fetch address
//   imem_rsp_valid  in-order instruction response, no backpressure
//   imem_rsp_data   instruction word
//   inst_valid      queue head valid
//   inst_ready      ID consumes the head
//   inst_code       head instruction
//   inst_pc4        head instruction address + 4
//
// Optional feature macro: IF_PREFETCH_BYPASS_EN
//   Defined   : a kept response arriving while the queue is empty is shown on
//               inst_* in the same cycle and skips the queue if consumed.
//   Undefined : inst_* come only from the queue head (one cycle latency).
// ---------------------------------------------------------------------------
module if_prefetch_queue
    import if_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter int          MAX_INFLIGHT = 4,
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_code,
    output logic [31:0] inst_pc4
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(MAX_INFLIGHT) + 1;
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic [IW-1:0] drop_q, drop_d;
    logic          run_q;
    fetch_entry_t  last_q, last_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;

    logic          req_fire;
    logic          rsp_keep;
    logic [SW-1:0] pending;
    logic          credit_ok;
    fetch_entry_t  rsp_entry;
    fetch_entry_t  out_entry;

    // Queue slots already promised: stored entries plus responses still owed
    // that will actually be kept (stale ones are excluded).
    assign pending   = SW'(fifo_count) + SW'(inflight_q) - SW'(drop_q);
    assign credit_ok = (inflight_q < IW'(MAX_INFLIGHT)) && (pending < SW'(DEPTH));

    // run_q keeps the request port quiet while reset is asserted; fetching
    // starts on the first clock after release.
    assign imem_req_valid = run_q && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is kept only when nothing stale is still outstanding and no
    // redirect is flushing this cycle.
    assign rsp_keep  = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign rsp_entry = '{pc4: next_pc(rsp_pc_q), code: imem_rsp_data};

    assign fifo_pop = !fifo_empty && inst_ready && !redirect_valid;

`ifdef IF_PREFETCH_BYPASS_EN
    logic bypass;

    // Empty queue: present the arriving word directly; it only enters the
    // queue if ID does not take it this cycle.
    assign bypass     = fifo_empty && rsp_keep;
    assign inst_valid = !fifo_empty || bypass;
    assign out_entry  = bypass ? rsp_entry : (fifo_empty ? last_q : fifo_head);
    assign fifo_push  = rsp_keep && !(bypass && inst_ready) && (!fifo_full || fifo_pop);
`else
    assign inst_valid = !fifo_empty;
    assign out_entry  = fifo_empty ? last_q : fifo_head;
    assign fifo_push  = rsp_keep && (!fifo_full || fifo_pop);
`endif

    assign inst_code = out_entry.code;
    assign inst_pc4  = out_entry.pc4;

    // Next-state for PCs and the outstanding/stale request counters. On a
    // redirect every request still owed (minus one answered this cycle) turns
    // stale; requests are blocked during redirect so none is added.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q + IW'(req_fire) - IW'(imem_rsp_valid);
        drop_d     = drop_q;
        last_d     = last_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_d     = inflight_q - IW'(imem_rsp_valid) + IW'(req_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = next_pc(fetch_pc_q);
            end
            if (rsp_keep) begin
                rsp_pc_d = next_pc(rsp_pc_q);
            end
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - IW'(1);
            end
        end

        // inst_code/inst_pc4 keep showing the last presented entry while the
        // queue is empty.
        if (inst_valid) begin
            last_d = out_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            run_q      <= 1'b0;
            last_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            run_q      <= 1'b1;
            last_q     <= last_d;
        end
    end

    prefetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (fifo_push),
        .push_data(rsp_entry),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .head     (fifo_head)
    );

endmodule

// File: tb/tb_if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_queue
// Self-checking bench for if_prefetch_queue. A memory model answers accepted
// requests after a programmable latency; expected request addresses and
// delivered instructions are queued by the stimulus and checked by separate
// monitor processes.
// Per cycle (period 10): negedge+0 stimulus, +1 memory drives responses and
// ready, +2 memory records handshake, +3 delivery monitor, +4 direct checks.
// ---------------------------------------------------------------------------
module tb_if_prefetch_queue;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_code;
    logic [31:0] inst_pc4;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] code;
    } deliv_t;

    pend_t       pendQ[$];
    logic [31:0] expReqQ[$];
    deliv_t      expDelQ[$];

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;
    int budget      = 0;
    int lat         = 1;
    int acceptCount = 0;
    int reqFirst    = 0;
    int reqLast     = 0;
    int delCount    = 0;
    int delFirst    = 0;
    int delLast     = 0;

    if_prefetch_queue #(
        .DEPTH       (4),
        .MAX_INFLIGHT(4),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_code     (inst_code),
        .inst_pc4      (inst_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: each word encodes its own address.
    function automatic logic [31:0] codeOf(input logic [31:0] addr);
        return {~addr[15:0], addr[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expectReq(input logic [31:0] addr);
        expReqQ.push_back(addr);
    endtask

    task automatic expectDel(input logic [31:0] pc4);
        deliv_t d;
        d.pc4  = pc4;
        d.code = codeOf(pc4 - 32'd4);
        expDelQ.push_back(d);
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] pc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = pc;
        inst_ready     = rdy;
    endtask

    // Memory model: in-order responses after 'lat' cycles, ready while budget
    // remains, and the request-address scoreboard check at each acceptance.
    always @(negedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!reset) begin
            pendQ.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
            imem_req_ready = 1'b0;
        end else begin
            if (pendQ.size() > 0 && pendQ[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = codeOf(pendQ[0].addr);
                void'(pendQ.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
            imem_req_ready = (budget > 0);
            #1;
            if (imem_req_valid && imem_req_ready) begin
                pend_t p;
                p.addr = imem_req_addr;
                p.due  = cyc + lat;
                pendQ.push_back(p);
                budget = budget - 1;
                if (acceptCount == 0) reqFirst = cyc;
                reqLast     = cyc;
                acceptCount = acceptCount + 1;
                if (expReqQ.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_req: got %h, expected no request", imem_req_addr);
                end else begin
                    checkOutput("req_addr", imem_req_addr, expReqQ.pop_front());
                end
            end
        end
    end

    // Delivery monitor: a handshake that will complete at the next edge is
    // compared against the head of the expected-delivery queue.
    always @(negedge clk) begin
        #3;
        if (reset && inst_valid && inst_ready && !redirect_valid) begin
            if (expDelQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_delivery: got pc4 %h, expected none", inst_pc4);
            end else begin
                deliv_t e;
                e = expDelQ.pop_front();
                checkOutput("deliver_pc4", inst_pc4, e.pc4);
                checkOutput("deliver_code", inst_code, e.code);
            end
            if (delCount == 0) delFirst = cyc;
            delLast  = cyc;
            delCount = delCount + 1;
        end
    end

    task automatic resetDut();
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        budget = 0;
        reset  = 1'b0;
        nextCycle();
        nextCycle();
        #4;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("rst_inst_code", inst_code, 32'h0);
        checkOutput("rst_inst_pc4", inst_pc4, 32'h0);
        nextCycle();
        reset       = 1'b1;
        acceptCount = 0;
        delCount    = 0;
    endtask

    task automatic waitAccepts(input int n);
        int i;
        i = 0;
        while (acceptCount < n && i < 100) begin
            nextCycle();
            i++;
        end
        if (acceptCount < n) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL wait_accepts: got %0d, expected %0d", acceptCount, n);
        end
    endtask

    task automatic waitDrain(input int limit);
        int i;
        i = 0;
        while ((expReqQ.size() != 0 || expDelQ.size() != 0) && i < limit) begin
            nextCycle();
            i++;
        end
        if (expReqQ.size() != 0 || expDelQ.size() != 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL drain_timeout: got %0d reqs %0d insts outstanding, expected 0",
                     expReqQ.size(), expDelQ.size());
            expReqQ.delete();
            expDelQ.delete();
        end
        repeat (3) nextCycle();
    endtask

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        // Streaming: ready memory, 1-cycle latency, ID always ready.
        $display("[TB] streaming fetch");
        resetDut();
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            expectReq(32'(i * 4));
            expectDel(32'(i * 4 + 4));
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        budget = 8;
        waitDrain(100);
        checkOutput("stream_req_count", 32'(acceptCount), 32'd8);
        checkOutput("stream_req_span", 32'(reqLast - reqFirst), 32'd7);
        checkOutput("stream_del_span", 32'(delLast - delFirst), 32'd7);

        // ID stall: the queue fills to DEPTH and fetching stops.
        $display("[TB] decode stall");
        resetDut();
        lat = 1;
        for (int i = 0; i < 6; i++) begin
            expectReq(32'(i * 4));
            expectDel(32'(i * 4 + 4));
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        budget = 6;
        repeat (10) nextCycle();
        #4;
        checkOutput("stall_req_count", 32'(acceptCount), 32'd4);
        checkOutput("stall_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("stall_inst_valid", 32'(inst_valid), 32'h1);
        checkOutput("stall_head_pc4", inst_pc4, 32'h4);
        checkOutput("stall_head_code", inst_code, codeOf(32'h0));
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitDrain(100);

        // Redirect with three requests outstanding at latency 3.
        $display("[TB] redirect with requests in flight");
        resetDut();
        lat = 3;
        expectReq(32'h0);
        expectReq(32'h4);
        expectReq(32'h8);
        expectReq(32'h100);
        expectReq(32'h104);
        expectDel(32'h104);
        expectDel(32'h108);
        applyStimulus(1'b0, 32'h0, 1'b1);
        budget = 3;
        waitAccepts(3);
        applyStimulus(1'b1, 32'h100, 1'b1);
        budget = 2;
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitDrain(100);

        // Redirect coinciding with a response and an attempted pop.
        $display("[TB] redirect with response and pop");
        resetDut();
        lat = 2;
        expectReq(32'h0);
        expectReq(32'h4);
        expectReq(32'h8);
        expectReq(32'h400);
        expectDel(32'h404);
        applyStimulus(1'b0, 32'h0, 1'b0);
        budget = 3;
        waitAccepts(3);
        applyStimulus(1'b1, 32'h400, 1'b1);
        budget = 1;
        #4;
        checkOutput("redir_cycle_inst_valid", 32'(inst_valid), 32'h1);
        checkOutput("redir_cycle_head_pc4", inst_pc4, 32'h4);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        #4;
        checkOutput("post_redir_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("post_redir_drop", 32'(dut.drop_q), 32'd1);
        checkOutput("post_redir_inflight", 32'(dut.inflight_q), 32'd1);
        waitDrain(100);

        // Two redirects one cycle apart; the 0x200 fetch must be discarded.
        $display("[TB] back-to-back redirects");
        resetDut();
        lat = 3;
        expectReq(32'h0);
        expectReq(32'h4);
        expectReq(32'h8);
        expectReq(32'h200);
        expectReq(32'h300);
        expectReq(32'h304);
        expectReq(32'h308);
        expectDel(32'h304);
        expectDel(32'h308);
        expectDel(32'h30C);
        applyStimulus(1'b0, 32'h0, 1'b1);
        budget = 3;
        waitAccepts(3);
        applyStimulus(1'b1, 32'h200, 1'b1);
        budget = 4;
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 32'h300, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitDrain(100);

        // Redirect to the last word of the address space.
        $display("[TB] address wrap");
        lat = 1;
        expectReq(32'hFFFF_FFFC);
        expectReq(32'h0);
        expectDel(32'h0);
        expectDel(32'h4);
        nextCycle();
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
        budget = 2;
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitDrain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Generates sequential fetch addresses to an instruction memory with variable latency, using a valid/ready request and an in-order response.
- Buffers returned instructions, each paired with its PC+4, in a small queue.
- Hands instructions to the ID stage under a valid/ready handshake; flushes on a redirect (branch or jump target) from later stages.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- MAX_INFLIGHT, 4, maximum outstanding memory requests, including ones to be dropped.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; word-aligned.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  fetch address.
- imem_rsp_valid  in  1  instruction word returned; responses arrive in request order; no backpressure.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  ID stage consumes the head (low = stall).
- inst_code  out  32  head instruction.
- inst_pc4  out  32  head instruction address + 4.

Behaviour:
- Reset values: fetch_pc=RESET_PC, rsp_pc=RESET_PC, queue empty, inflight=0, drop=0, imem_req_valid=0, inst_valid=0, inst_code=0, inst_pc4=0. Reset is asynchronous and may assert mid-transaction; after reset, any late memory responses are the environment's responsibility.
- Credit rule: imem_req_valid = !redirect_valid && inflight<MAX_INFLIGHT && (count + inflight - drop) < DEPTH. imem_req_addr = fetch_pc.
- Request acceptance: on imem_req_valid && imem_req_ready, fetch_pc += 4 and inflight++. While no redirect occurs, imem_req_valid and imem_req_addr hold stable until accepted.
- Response handling: on imem_rsp_valid, inflight--.
  - If drop>0: drop-- and the word is discarded.
  - Otherwise: push {rsp_pc+4, imem_rsp_data} and rsp_pc += 4.
- Latency: a response becomes visible on inst_* the cycle after it arrives (feature off).
- Pop: when inst_valid && inst_ready. Push and pop in the same cycle are both legal; when full, pop and push together keep the count unchanged.
- Full/empty: the credit rule guarantees no push when full. inst_valid = (count != 0). inst_code and inst_pc4 hold their previous values while the queue is empty.
- Redirect: the cycle after redirect_valid:
  - queue empty;
  - fetch_pc = rsp_pc = redirect_pc;
  - drop = inflight - (imem_rsp_valid ? 1 : 0) + (accepted request ? 1 : 0), where the accepted-request term is always 0 because requests are suppressed during redirect.
- Redirect simultaneous with events:
  - any pop that cycle is ignored;
  - a response arriving that cycle is dropped;
  - back-to-back redirects accumulate drop correctly.
- Counter widths: $clog2(DEPTH)+1 for count; $clog2(MAX_INFLIGHT)+1 for inflight and drop. PC arithmetic is modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0.

Optional Feature:
- Macro: IF_PREFETCH_BYPASS_EN.
- Defined: when the queue is empty, no redirect is active, and a non-dropped response arrives, that response drives inst_valid/inst_code/inst_pc4 combinationally in the same cycle. If inst_ready is high it is consumed without being written to the queue; otherwise it is pushed normally. Throughput is unchanged; latency becomes 0.
- Undefined: no combinational path from imem_rsp_* to inst_*; inst_* come only from the queue head.

Decomposition:
- Shared package if_pkg holds:
  - WORD_WIDTH=32;
  - PC_STEP=4;
  - default RESET_PC;
  - typedef fetch_entry_t = packed struct {pc4[31:0], code[31:0]}.
- One sub-module: prefetch_fifo, a synchronous FIFO of fetch_entry_t with DEPTH entries.
  - Ports: push, pop, flush, full, empty, count, head.
  - Asynchronous active-low reset; flush has priority over push and pop.

Test Plan:
- Reset, then memory ready every cycle with 1-cycle response latency and inst_ready=1. Required: requests to 0x0, 0x4, 0x8, 0xC on consecutive cycles; inst_pc4 = 0x4, 0x8, 0xC, ...; one instruction per cycle sustained.
- inst_ready=0 for 10 cycles. Required: exactly DEPTH=4 requests issued, then imem_req_valid=0; inst_valid stays 1 with head inst_pc4=0x4; on release, drains in order 0x4..0x10.
- Memory latency 3 cycles, 3 requests in flight, redirect_pc=0x100. Required: the 3 stale responses are discarded; next request addr=0x100; first delivered inst_pc4=0x104.
- Redirect in the same cycle as imem_rsp_valid and inst_ready=1. Required: the response is dropped, the pop is ignored, the queue is empty next cycle, and drop = inflight-1.
- Two redirects 1 cycle apart (0x200, then 0x300) with responses pending. Required: no instruction from 0x200 is delivered; first delivered inst_pc4=0x304.
- Redirect to 0xFFFF_FFFC. Required: the next fetch address wraps to 0x0; delivered inst_pc4 values are 0x0 then 0x4.
